// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: opcodes and frame states shared by the SPI register port
package spi_reg_pkg;
  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_FAST = 2'b11;
  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT} state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: rise/fall pulses for one SPI pad input
// SPI_REG_SYNC_EN inserts a 2-flop synchroniser ahead of the edge detector
module spi_edge_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q, prev;
`ifdef SPI_REG_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) sync <= '0;
    else sync <= {sync[0], d};
  assign q = sync[1];
`else
  assign q = d;
`endif
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) prev <= 1'b0;
    else prev <= q;
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_mode.sv
// spi_reg_mode: SPI slave register port with runtime CPOL/CPHA, burst access and abort detection
// SPI_REG_SYNC_EN: synchronise sclk/nss/mosi to clk (otherwise they must already be synchronous)
module spi_reg_mode
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              cpol,
  input  logic              cpha,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd_en,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_vld,
  input  logic [7:0]        status,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld,
  output logic              frame_err
);
  logic sclk_r, sclk_f, nss_r, nss_f, mosi_q;
  spi_edge_sync u_sclk (.clk(clk), .nrst(nrst), .d(sclk), .rise(sclk_r), .fall(sclk_f));
  spi_edge_sync u_nss  (.clk(clk), .nrst(nrst), .d(nss),  .rise(nss_r),  .fall(nss_f));
`ifdef SPI_REG_SYNC_EN
  logic [1:0] mosi_s;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) mosi_s <= '0;
    else mosi_s <= {mosi_s[0], mosi};
  assign mosi_q = mosi_s[1];
`else
  assign mosi_q = mosi;
`endif
  state_t            state;
  logic              cpol_l, cpha_l;
  logic [REG_W-1:0]  osr, osr_nxt, word, st_w;
  logic [REG_W-2:0]  isr;
  logic [5:0]        cnt;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cmd;
  logic              lead, trail, act, smp, chg, last;
  assign lead  = cpol_l ? sclk_f : sclk_r;
  assign trail = cpol_l ? sclk_r : sclk_f;
  assign act   = state == CMD || state == DATA;
  assign smp   = act && (cpha_l ? trail : lead);
  assign chg   = act && (cpha_l ? lead : trail);
  assign last  = cnt == (state == CMD ? 6'd7 : 6'(REG_W - 1));
  assign word  = {isr, mosi_q};
  assign cmd   = word[7:0];
  assign st_w  = REG_W'(status) << (REG_W - 8);
  assign miso     = osr[REG_W-1];
  assign miso_oe  = state != IDLE;
  assign reg_addr = addr;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      {cpol_l, cpha_l} <= '0;
      osr <= '0;
      osr_nxt <= '0;
      isr <= '0;
      cnt <= '0;
      op <= '0;
      addr <= '0;
      reg_rd_en <= 1'b0;
      reg_data_o <= '0;
      reg_data_o_vld <= 1'b0;
      fastcmd <= '0;
      fastcmd_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_rd_en <= 1'b0;
      reg_data_o_vld <= 1'b0;
      fastcmd_vld <= 1'b0;
      frame_err <= 1'b0;
      if (reg_rd_en) osr_nxt <= reg_data_i;
      // the address advances on the cycle its read/write strobe is visible
      if (reg_rd_en || reg_data_o_vld) addr <= addr + 1'b1;
      if (chg) osr <= cnt == '0 ? osr_nxt : osr << 1;
      if (smp) begin
        isr <= word[REG_W-2:0];
        cnt <= last ? '0 : cnt + 1'b1;
        if (last && state == CMD) begin
          op <= cmd[7:6];
          addr <= cmd[ADDR_W-1:0];
          osr_nxt <= '0;
          reg_rd_en <= cmd[7:6] == CMD_RD;
          fastcmd_vld <= cmd[7:6] == CMD_FAST;
          if (cmd[7:6] == CMD_FAST) fastcmd <= cmd[5:0];
          if (cmd[6]) osr <= '0;
          state <= cmd[6] ? WAIT : DATA;
        end else if (last) begin
          reg_rd_en <= op == CMD_RD;
          reg_data_o_vld <= op == CMD_WR;
          if (op == CMD_WR) reg_data_o <= word;
        end
      end
      if (state == IDLE && nss_f) begin
        state <= CMD;
        cpol_l <= cpol;
        cpha_l <= cpha;
        osr <= st_w;
        osr_nxt <= st_w;
        cnt <= '0;
      end else if (state != IDLE && nss_r) begin
        // a sample landing with the nss rise finishes its word before the abort check
        state <= IDLE;
        frame_err <= smp ? !last : cnt != '0;
      end
    end
endmodule
